// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI memory controller.
package spi_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ctrl_op_e;

    typedef enum logic {
        PC  = 1'b0,
        MAR = 1'b1
    } addr_sel_e;

    // Controller FSM encoding, kept as plain constants for older tools.
    typedef logic [2:0] spi_mem_state_e;
    localparam spi_mem_state_e IDLE = 3'd0;
    localparam spi_mem_state_e CMD  = 3'd1;
    localparam spi_mem_state_e ADDR = 3'd2;
    localparam spi_mem_state_e DATA = 3'd3;
    localparam spi_mem_state_e DONE = 3'd4;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/spi_mem_ctrl_shifter.sv
// One SPI byte at a time: parallel load, MSB-first shift out, mode-0 capture.
module spi_byte_shifter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_byte,
    input  logic         miso,
    output logic         sck,
    output logic         mosi,
    output logic         byte_done,
    output logic [W-1:0] rx_byte
);

    logic [W-1:0] sh;
    logic         phase;
    logic [2:0]   bit_cnt;

    // Phase 0 -> 1 raises sck and samples miso; phase 1 -> 0 moves to the next bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sh      <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            rx_byte <= '0;
        end else if (load) begin
            sh      <= load_byte;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (en) begin
            if (!phase) begin
                phase   <= 1'b1;
                rx_byte <= {rx_byte[W-2:0], miso};
            end else begin
                phase   <= 1'b0;
                sh      <= {sh[W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign sck       = en & phase;
    assign mosi      = en & sh[W-1];
    assign byte_done = en & phase & (bit_cnt == 3'd7);

endmodule

// File: rtl/spi_mem_ctrl.sv
// Serves CPU memory requests over a shared SPI bus: PC -> flash, MAR -> serial SRAM.
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter int DATA_BUS_WIDTH   = 8,
    parameter int ADDR_WIDTH       = 16,
    parameter int FLASH_ADDR_BYTES = 3,
    parameter int RAM_ADDR_BYTES   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  addr_sel_e                 mem_addr_sel,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_cs_flash_n,
    output logic                      spi_cs_ram_n
);

    localparam int FAW = 8 * FLASH_ADDR_BYTES;

    spi_mem_state_e            state;
    logic                      armed;
    logic                      is_write;
    logic                      is_flash;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_BUS_WIDTH-1:0] data_q;
    logic [2:0]                byte_idx;

    logic                      busy, accept, illegal, load, byte_done;
    logic [2:0]                n_addr, next_idx, last_idx;
    logic [FAW-1:0]            addr_ext;
    logic [DATA_BUS_WIDTH-1:0] cmd_byte, next_byte, load_byte, rx_byte;

    assign busy     = (state == CMD) || (state == ADDR) || (state == DATA);
    assign accept   = (state == IDLE) && armed && (mem_ctrl_op != MEM_NOP);
    assign illegal  = (mem_ctrl_op == MEM_WRITE) && (mem_addr_sel == PC);
    assign cmd_byte = (mem_ctrl_op == MEM_WRITE) ? SPI_CMD_WRITE : SPI_CMD_READ;

    // Byte 0 is the command, then the address bytes MSB first, then the data byte.
    assign addr_ext = FAW'(addr_q);
    assign n_addr   = is_flash ? 3'(FLASH_ADDR_BYTES) : 3'(RAM_ADDR_BYTES);
    assign next_idx = byte_idx + 3'd1;
    assign last_idx = n_addr + 3'd1;

    // Pick the byte that follows the one currently on the wire.
    always_comb begin
        next_byte = '0;
        if (next_idx <= n_addr)
            next_byte = addr_ext[{n_addr - next_idx, 3'b000} +: 8];
        else if (is_write)
            next_byte = data_q;
    end

    assign load      = (accept && !illegal) || (byte_done && state != DATA);
    assign load_byte = (state == IDLE) ? cmd_byte : next_byte;

    spi_byte_shifter #(.W(DATA_BUS_WIDTH)) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .en        (busy),
        .load      (load),
        .load_byte (load_byte),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    // Request acceptance, byte sequencing and read-data capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            is_write <= 1'b0;
            is_flash <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            byte_idx <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_ctrl_op == MEM_NOP) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed    <= 1'b0;
                        is_write <= (mem_ctrl_op == MEM_WRITE);
                        is_flash <= (mem_addr_sel == PC);
                        addr_q   <= address;
                        data_q   <= data_in;
                        byte_idx <= '0;
                        state    <= illegal ? DONE : CMD;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (byte_done) begin
                        byte_idx <= next_idx;
                        if (state == DATA) begin
                            state <= DONE;
                            if (!is_write)
                                data_out <= rx_byte;
                        end else if (next_idx == last_idx) begin
                            state <= DATA;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_op_done    = (state == DONE);
    assign spi_cs_flash_n = !(busy && is_flash);
    assign spi_cs_ram_n   = !(busy && !is_flash);

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Randomized and directed bench for spi_mem_ctrl against a transaction-level model.
module tb_spi_mem_ctrl;
    import spi_mem_ctrl_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    mem_ctrl_op_e op = MEM_NOP;
    addr_sel_e    sel = PC;
    logic [15:0]  address = '0;
    logic [7:0]   data_in = '0;
    logic         miso = 1'b0;
    logic [7:0]   data_out;
    logic         mem_op_done, spi_sck, spi_mosi, spi_cs_flash_n, spi_cs_ram_n;

    spi_mem_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .mem_ctrl_op    (op),
        .mem_addr_sel   (sel),
        .address        (address),
        .data_in        (data_in),
        .data_out       (data_out),
        .mem_op_done    (mem_op_done),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (miso),
        .spi_cs_flash_n (spi_cs_flash_n),
        .spi_cs_ram_n   (spi_cs_ram_n)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0, cyc = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: cycle index since acceptance, expected bit stream.
    int         m_k = -1, m_end = 0, m_nbits = 0, m_acc = 0;
    bit         m_armed = 0, m_flash = 0, m_read = 0, m_ill = 0;
    logic [39:0] m_bits = '0;
    logic [7:0] m_rb = '0, m_dout = '0, next_rb = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_k = -1; m_armed = 0; m_dout = '0;
        end else if (m_k >= 0) begin
            if (m_k == m_end) m_k = -1;
            else begin
                m_k++;
                if (m_k == m_end && m_read && !m_ill) m_dout = m_rb;
            end
        end else if (op == MEM_NOP) begin
            m_armed = 1;
        end else if (m_armed) begin
            m_armed = 0; m_acc = cyc;
            m_flash = (sel == PC);
            m_read  = (op != MEM_WRITE);
            m_ill   = !m_read && m_flash;
            m_rb    = next_rb;
            if (m_flash) begin
                m_bits = {8'h03, 8'h00, address, 8'h00}; m_nbits = 40;
            end else begin
                m_bits = {(m_read ? 8'h03 : 8'h02), address, (m_read ? 8'h00 : data_in), 8'h00};
                m_nbits = 32;
            end
            m_end = m_ill ? 1 : 2 * m_nbits + 1;
            m_k = 1;
        end
        cyc++;
    end

    // Per-cycle compare against the model; also plays the SPI slave on miso.
    bit e_busy, e_done;
    int e_b;
    always @(negedge clock) begin
        e_busy = (m_k >= 1) && !m_ill && (m_k <= 2 * m_nbits);
        e_done = (m_k >= 1) && (m_k == m_end);
        e_b    = (m_k - 1) / 2;
        chk("done", 64'(mem_op_done), 64'(e_done));
        chk("sck", 64'(spi_sck), 64'(e_busy && (m_k % 2 == 0)));
        chk("cs_flash_n", 64'(spi_cs_flash_n), 64'(!(e_busy && m_flash)));
        chk("cs_ram_n", 64'(spi_cs_ram_n), 64'(!(e_busy && !m_flash)));
        chk("data_out", 64'(data_out), 64'(m_dout));
        if (e_busy) chk("mosi", 64'(spi_mosi), 64'(m_bits[39 - e_b]));
        if (e_busy && m_read && (m_k % 2 == 1) && e_b >= m_nbits - 8)
            miso = m_rb[7 - (e_b - (m_nbits - 8))];
        else
            miso = 1'($urandom_range(0, 1));
    end

    // Bus observer: running totals that directed tests difference.
    logic        prev_sck = 1'b0;
    int          rises = 0, csf_low = 0, csr_low = 0, dones = 0, done_at = -1;
    logic [63:0] mon_word = '0;
    always @(negedge clock) begin
        if (spi_sck && !prev_sck) begin
            rises++;
            mon_word = {mon_word[62:0], spi_mosi};
        end
        prev_sck = spi_sck;
        if (!spi_cs_flash_n) csf_low++;
        if (!spi_cs_ram_n) csr_low++;
        if (mem_op_done) begin dones++; done_at = cyc - m_acc; end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Issue one request (block must be armed), scramble inputs after acceptance,
    // wait for done, hold the op for 'hold' cycles, then re-arm with NOP.
    task automatic txn(mem_ctrl_op_e o, addr_sel_e s, logic [15:0] a, logic [7:0] d,
                       logic [7:0] rb, int hold);
        int n;
        op = o; sel = s; address = a; data_in = d; next_rb = rb;
        n = 0;
        do begin
            tick(); n++;
            address = 16'($urandom); data_in = 8'($urandom); sel = addr_sel_e'($urandom_range(0, 1));
        end while (!mem_op_done && n < 300);
        if (!mem_op_done) begin
            tests++; fails++;
            $display("FAIL timeout: no done after %0d cycles, expected one", n);
        end
        repeat (hold) tick();
        op = MEM_NOP; tick(); tick();
    endtask

    int r0, f0, c0, d0;
    initial begin
        repeat (3) tick();
        chk("rst data_out", 64'(data_out), 64'h0);
        chk("rst cs_flash_n", 64'(spi_cs_flash_n), 64'h1);
        chk("rst cs_ram_n", 64'(spi_cs_ram_n), 64'h1);
        chk("rst done", 64'(mem_op_done), 64'h0);
        chk("rst sck", 64'(spi_sck), 64'h0);
        reset = 1'b1; tick(); tick();

        // RAM write
        f0 = csf_low; c0 = csr_low;
        txn(MEM_WRITE, MAR, 16'h1234, 8'hA5, 8'h00, 0);
        chk("ramwr mosi", mon_word[31:0], 64'h021234A5);
        chk("ramwr done_at", 64'(done_at), 64'd65);
        chk("ramwr cs_ram cycles", 64'(csr_low - c0), 64'd64);
        chk("ramwr cs_flash cycles", 64'(csf_low - f0), 64'd0);

        // Flash read
        f0 = csf_low;
        txn(MEM_READ, PC, 16'h00FF, 8'h00, 8'h3C, 0);
        chk("flrd mosi", mon_word[39:0], 64'h030000FF00);
        chk("flrd done_at", 64'(done_at), 64'd81);
        chk("flrd cs_flash cycles", 64'(csf_low - f0), 64'd80);
        chk("flrd data_out", 64'(data_out), 64'h3C);

        // Illegal flash write
        r0 = rises; f0 = csf_low; c0 = csr_low;
        txn(MEM_WRITE, PC, 16'h4444, 8'h55, 8'h00, 0);
        chk("illegal done_at", 64'(done_at), 64'd1);
        chk("illegal sck rises", 64'(rises - r0), 64'd0);
        chk("illegal cs cycles", 64'((csf_low - f0) + (csr_low - c0)), 64'd0);
        chk("illegal data_out", 64'(data_out), 64'h3C);

        // Held op: two transactions only
        d0 = dones; r0 = rises;
        txn(MEM_READ, MAR, 16'h0102, 8'h00, 8'h5A, 3);
        txn(MEM_READ, MAR, 16'h0304, 8'h00, 8'hA5, 0);
        chk("held dones", 64'(dones - d0), 64'd2);
        chk("held sck rises", 64'(rises - r0), 64'd64);

        // Reset mid RAM read at cycle 30, READ held through release
        d0 = dones;
        op = MEM_READ; sel = MAR; address = 16'h7777; next_rb = 8'h99;
        repeat (30) tick();
        reset = 1'b0; tick();
        chk("midrst cs_ram_n", 64'(spi_cs_ram_n), 64'h1);
        chk("midrst sck", 64'(spi_sck), 64'h0);
        chk("midrst done", 64'(mem_op_done), 64'h0);
        reset = 1'b1;
        r0 = rises;
        repeat (10) tick();
        chk("midrst no restart rises", 64'(rises - r0), 64'd0);
        chk("midrst no done", 64'(dones - d0), 64'd0);
        op = MEM_NOP; tick(); tick();

        // Back-to-back reads
        txn(MEM_READ, MAR, 16'hBEEF, 8'h00, 8'h81, 0);
        chk("b2b first data_out", 64'(data_out), 64'h81);
        txn(MEM_READ, PC, 16'hCAFE, 8'h00, 8'h7E, 0);
        chk("b2b second data_out", 64'(data_out), 64'h7E);

        // Random traffic
        for (int i = 0; i < 25; i++)
            txn(mem_ctrl_op_e'($urandom_range(1, 2)), addr_sel_e'($urandom_range(0, 1)),
                16'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Memory-interface controller that serves the CPU control unit's memory requests (mem_ctrl_op / mem_op_done handshake) over a single SPI bus. The bus is shared by an external program flash and an external serial SRAM. The addr_sel value routes each request: PC means flash (program and constant fetch), MAR means RAM (data). The block sequences the complete SPI transaction (chip select, command, address, data) and returns a one-cycle done pulse, plus the read byte for reads.

Parameters:
DATA_BUS_WIDTH, 8, data byte width; fixed at 8 for SPI byte framing
ADDR_WIDTH, 16, width of the address input from the address registers
FLASH_ADDR_BYTES, 3, address bytes sent to flash; upper bits zero-extended
RAM_ADDR_BYTES, 2, address bytes sent to RAM

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
mem_ctrl_op  input  2  mem_ctrl_op_e: MEM_NOP, MEM_READ or MEM_WRITE; held by the controller until it sees done
mem_addr_sel  input  1  addr_sel_e: PC selects flash, MAR selects RAM
address  input  ADDR_WIDTH  byte address from the selected address register
data_in  input  DATA_BUS_WIDTH  write data from the datapath (ALU pass-through)
data_out  output  DATA_BUS_WIDTH  last byte read; drives the bus on MUX_MEM
mem_op_done  output  1  one-cycle completion pulse
spi_sck  output  1  SPI clock, mode 0, frequency clock/2
spi_mosi  output  1  serial data out, MSB first
spi_miso  input  1  serial data in
spi_cs_flash_n  output  1  flash chip select, active low
spi_cs_ram_n  output  1  RAM chip select, active low

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, spi_sck=0, spi_mosi=0, both CS_n=1, mem_op_done=0, data_out=0, armed=0. This applies mid-transaction: CS is released immediately, no done is issued, and the latched request is discarded.
- armed flag: set in IDLE whenever mem_ctrl_op==MEM_NOP; cleared when a request is accepted. A request is accepted only in IDLE with armed==1 and op!=MEM_NOP. This absorbs the cycles in which the controller still holds the op after done.
- Acceptance cycle: latch op, mem_addr_sel, address and data_in. Later changes on these inputs are ignored until the next acceptance.
- Illegal request (MEM_WRITE with mem_addr_sel==PC): no SPI activity; mem_op_done pulses in the cycle after acceptance; data_out unchanged.
- States: IDLE -> CMD (8 bits) -> ADDR (16 or 24 bits) -> DATA (8 bits) -> DONE -> IDLE.
- Command byte: 0x03 for a read, 0x02 for a RAM write.
- Address bytes: flash gets {zero-extend, address} as 3 bytes; RAM gets address[15:0] as 2 bytes. MSB first in both cases.
- Bit timing: each bit takes 2 cycles.
  - Phase 0: sck=0; mosi is updated at the start of this phase.
  - Phase 1: sck=1.
  - miso is registered on the clock edge where sck rises.
- Chip select: the selected CS_n goes low in the first CMD cycle and stays low through the last DATA phase-1 cycle. The other CS_n stays high throughout.
- DATA phase: a write shifts out the latched data_in; a read drives mosi=0 and shifts in 8 miso bits.
- DONE state, one cycle: both CS_n=1, sck=0, mem_op_done=1. For reads, data_out takes the assembled byte in this same cycle and holds it until the next read completes.
- Latency, counted from the acceptance cycle = 0:
  - RAM read or write: CS low in cycles 1..64, done in cycle 65.
  - Flash read: CS low in cycles 1..80, done in cycle 81.
- A bit counter sized for 40 bits moves from CMD to ADDR to DATA at byte boundaries. There is no wrap into a next transaction; sequential bursts are not supported.
- Simultaneous events: a change of op in the acceptance cycle has no effect. An op other than NOP during DONE does not re-arm the block.

Decomposition:
- Shared package:
  - mem_ctrl_op_e and addr_sel_e (existing).
  - New spi_mem_state_e (IDLE, CMD, ADDR, DATA, DONE).
  - Constants SPI_CMD_READ=8'h03 and SPI_CMD_WRITE=8'h02.
- One natural sub-module, spi_byte_shifter. It is an 8-bit parallel-load shift register with a phase bit and a bit count. It generates sck and mosi, captures miso, and flags byte-complete. The top level owns the FSM, the latches and the CS decode.

Test Plan:
- RAM write: op=WRITE, sel=MAR, address=0x1234, data_in=0xA5 -> MOSI carries 0x02,0x12,0x34,0xA5; cs_ram_n low for cycles 1..64; done in cycle 65; cs_flash_n stays 1.
- Flash read: op=READ, sel=PC, address=0x00FF, MISO model returns 0x3C -> MOSI carries 0x03,0x00,0x00,0xFF; done in cycle 81; data_out=0x3C.
- Held op: op held at READ for 3 cycles after done, then NOP, then READ -> only two transactions are seen on the SPI bus.
- Illegal request: op=WRITE, sel=PC -> done in cycle 1, CS stays high, sck never toggles, data_out unchanged.
- Reset mid-operation: assert reset at cycle 30 of a RAM read -> next cycle CS_n=1, sck=0, no done. A READ held through the reset release does not start until NOP is seen.
- Back-to-back: RAM read returning 0x81, then flash read returning 0x7E -> data_out=0x81 from the first done until the second done, then 0x7E.
